ms_serial_mouse_rx: RTL and testbench
=====================================

# ms_serial_mouse_rx

- Receives the Microsoft serial-mouse stream (1200 baud, 7N1, 3-byte packets) on an RS-232-level-converted RX line.
- Recovers button states and signed X/Y deltas, and presents one single-cycle strobe per complete packet.
- Also detects the 'M' identification byte that a mouse sends after RTS is raised.
- Sits on the host/UART side of the design, as the receiving end of a serial mouse link.

## Interface
- CLKFREQ, 50_000_000: system clock frequency in Hz.
- BAUDRATE, 1_200: serial bit rate; bit period BP = CLKFREQ/BAUDRATE cycles, half period HP = BP/2.
- TIMEOUT_MS, 10: inter-byte timeout in ms; only used when MSRX_TIMEOUT_EN is defined.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial data from mouse; idle high; asynchronous to clk.
- rts  in  1  host RTS level; asynchronous to clk.
- packet_valid  out  1  one-cycle strobe when dx/dy/lbut/rbut are updated.
- dx  out  8  signed X delta, two's complement, positive = right.
- dy  out  8  signed Y delta, two's complement, positive = down (serial-mouse convention, no inversion).
- lbut  out  1  left button, 1 = pressed.
- rbut  out  1  right button, 1 = pressed.
- ident_valid  out  1  one-cycle strobe when 'M' (7'h4D) is the first byte after an RTS rise.
- frame_err  out  1  one-cycle strobe on bad stop bit.
- sync_err  out  1  one-cycle strobe when a byte with bit6=0 arrives with no header pending.

## Operation
- rxd and rts each pass through a 2-flop synchronizer. The RTS rise detector compares the synchronized value against its previous value.
- Receiver FSM, with a down-counter for bit timing:
  - IDLE: a falling rxd loads HP, then go to START.
  - START: when the counter expires, if rxd is still 0 load BP and go to DATA. If rxd is 1, treat it as a glitch and return to IDLE silently.
  - DATA: sample rxd at each BP expiry, shifting LSB first into a 7-bit register. After 7 bits, load BP and go to STOP.
  - STOP: at counter expiry, rxd=1 means the byte is complete (one-cycle internal byte_done) and go to IDLE. rxd=0 pulses frame_err, discards the byte, and goes to WAIT_HI.
  - WAIT_HI: stay until rxd=1, then go to IDLE.
  - Extra stop bits (line stays high) are accepted as idle.
- Packet assembler, with index idx in {0,1,2}, runs on byte_done:
  - Byte with bit6=1, at any idx: store it as b1 and set idx=1. A header arriving mid-packet resynchronizes and drops the partial packet.
  - Byte with bit6=0 at idx=0: pulse sync_err and discard it.
  - Byte with bit6=0 at idx=1: store it as b2 and set idx=2.
  - Byte with bit6=0 at idx=2: set idx=0 and, in the same cycle, register the outputs and pulse packet_valid:
    - lbut=b1[5], rbut=b1[4]
    - dx={b1[1:0], b2[5:0]}
    - dy={b1[3:2], b3[5:0]}
- Ident window:
  - An RTS rise aborts any byte in progress (FSM to IDLE), sets idx=0, and arms an ident flag.
  - The next byte_done clears the flag. If that byte is 7'h4D, pulse ident_valid and do not feed the byte to the assembler; otherwise the byte is processed normally.
- Outputs hold their values between packets.

## Timing
- Reset: all outputs are 0, FSM is IDLE, idx=0, ident flag is clear, counters are 0.
- Reset asserted mid-frame aborts immediately. After release, a frame already in progress on the line may produce frame_err or be missed; no partial data is ever output.
- A valid start bit is confirmed HP cycles after the falling edge. Data bit n is sampled HP+(n+1)·BP cycles after the edge; the stop bit is sampled at HP+8·BP.
- packet_valid, ident_valid, frame_err and sync_err assert 1 cycle after the stop-bit sample, all registered.
- Synchronizer latency adds 2 cycles to every edge.
- If an RTS rise and byte_done occur in the same cycle, the RTS rise wins: the byte is dropped and the ident flag is armed.
- No backpressure: a consumer must capture the outputs on packet_valid.

## Configuration
- MSRX_TIMEOUT_EN defined:
  - A counter of TIMEOUT_MS·CLKFREQ/1000 cycles reloads on every byte_done and counts down while idx≠0 and the FSM is IDLE.
  - At zero, idx returns to 0 and the partial packet is dropped silently.
- MSRX_TIMEOUT_EN undefined: the counter is absent and a partial packet waits indefinitely.

## Test plan
- Send bytes 0x6C, 0x05, 0x3D at 1200 baud -> one packet_valid with lbut=1, rbut=0, dx=8'h05, dy=8'hFD.
- Raise rts, then send 0x4D -> ident_valid pulse with no packet_valid. A following 0x50, 0x00, 0x00 -> rbut=1, dx=0, dy=0.
- Send a byte with stop bit forced to 0 -> frame_err pulse, no packet_valid. The line is then held low for 5 ms before release; a subsequent good packet decodes correctly.
- Send 0x40, 0x01, then a new header 0x60, 0x02, 0x03 -> exactly one packet_valid with lbut=1, dx=8'h02, dy=8'h03.
- Apply a 0.2·BP low glitch on rxd -> no strobes. Send a lone 0x12 -> sync_err pulse.
- With MSRX_TIMEOUT_EN defined: send 0x40, 0x01, wait 15 ms, send 0x05 -> sync_err and no packet_valid. Without the macro -> packet_valid with dx=8'h01, dy=8'h05.

Source files
------------

// File: rtl/ms_serial_mouse_rx.sv
// Microsoft serial-mouse receiver: 7N1 byte receiver, 3-byte packet assembler and 'M' ident detect.
// Optional MSRX_TIMEOUT_EN drops a partial packet after TIMEOUT_MS of line idle.
module ms_serial_mouse_rx #(
    parameter int CLKFREQ    = 50_000_000,
    parameter int BAUDRATE   = 1_200,
    parameter int TIMEOUT_MS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rts,
    output logic       packet_valid,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic       lbut,
    output logic       rbut,
    output logic       ident_valid,
    output logic       frame_err,
    output logic       sync_err
);
    localparam int BP = CLKFREQ / BAUDRATE;
    localparam int HP = BP / 2;
    localparam int CW = $clog2(BP + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bitn, bitn_nx;
    logic [6:0]    shreg, shreg_nx;
    logic          byte_done, stop_bad, expired;
    logic          rxd_m, rxd_s, rxd_d, rts_m, rts_s, rts_d, rts_rise;
    logic [1:0]    idx;
    logic          ident_arm;
    logic [5:0]    b1, b2;

`ifdef MSRX_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_MS * (CLKFREQ / 1000);
    localparam int TW     = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt;
`endif

    // rxd synchronizer resets high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_m <= 1'b1; rxd_s <= 1'b1; rxd_d <= 1'b1;
            rts_m <= 1'b0; rts_s <= 1'b0; rts_d <= 1'b0;
        end else begin
            rxd_m <= rxd;  rxd_s <= rxd_m; rxd_d <= rxd_s;
            rts_m <= rts;  rts_s <= rts_m; rts_d <= rts_s;
        end
    end

    assign rts_rise = rts_s & ~rts_d;
    assign expired  = (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            bitn  <= bitn_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        bitn_nx   = bitn;
        shreg_nx  = shreg;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (state != S_IDLE && state != S_WAIT_HI && !expired)
            cnt_nx = cnt - CW'(1);
        case (state)
            S_IDLE: begin
                if (rxd_d && !rxd_s) begin
                    cnt_nx   = CW'(HP - 1);
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (expired) begin
                    if (!rxd_s) begin
                        cnt_nx   = CW'(BP - 1);
                        bitn_nx  = '0;
                        state_nx = S_DATA;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shreg_nx = {rxd_s, shreg[6:1]};
                    cnt_nx   = CW'(BP - 1);
                    if (bitn == 3'd6) state_nx = S_STOP;
                    else              bitn_nx  = bitn + 3'd1;
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nx  = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rxd_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (rts_rise) state_nx = S_IDLE;
    end

    // Packet assembler; an RTS rise takes priority over a byte finishing in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            packet_valid <= 1'b0; ident_valid <= 1'b0; frame_err <= 1'b0; sync_err <= 1'b0;
            dx <= '0; dy <= '0; lbut <= 1'b0; rbut <= 1'b0;
            idx <= '0; ident_arm <= 1'b0; b1 <= '0; b2 <= '0;
`ifdef MSRX_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            packet_valid <= 1'b0;
            ident_valid  <= 1'b0;
            sync_err     <= 1'b0;
            frame_err    <= stop_bad & ~rts_rise;
            if (rts_rise) begin
                idx       <= '0;
                ident_arm <= 1'b1;
            end else if (byte_done) begin
`ifdef MSRX_TIMEOUT_EN
                to_cnt <= TW'(TO_CYC);
`endif
                ident_arm <= 1'b0;
                if (ident_arm && shreg == 7'h4D) begin
                    ident_valid <= 1'b1;
                end else if (shreg[6]) begin
                    b1  <= shreg[5:0];
                    idx <= 2'd1;
                end else begin
                    case (idx)
                        2'd0: sync_err <= 1'b1;
                        2'd1: begin
                            b2  <= shreg[5:0];
                            idx <= 2'd2;
                        end
                        default: begin
                            idx          <= 2'd0;
                            packet_valid <= 1'b1;
                            lbut         <= b1[5];
                            rbut         <= b1[4];
                            dx           <= {b1[1:0], b2};
                            dy           <= {b1[3:2], shreg[5:0]};
                        end
                    endcase
                end
            end
`ifdef MSRX_TIMEOUT_EN
            else if (idx != 2'd0 && state == S_IDLE) begin
                if (to_cnt == '0) idx    <= 2'd0;
                else              to_cnt <= to_cnt - TW'(1);
            end
`endif
        end
    end
endmodule

// File: tb/tb_ms_serial_mouse_rx.sv
// Self-checking bench for ms_serial_mouse_rx: scenario tasks against a byte-level packet model.
// Uses a scaled clock (60 kHz, 1200 baud -> 50 cycles per bit) to keep runs short.
module tb_ms_serial_mouse_rx;
    localparam int CLKFREQ = 60_000;
    localparam int BAUD    = 1_200;
    localparam int TMO_MS  = 10;
    localparam int BPC     = CLKFREQ / BAUD;
    localparam int MS      = CLKFREQ / 1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rts = 1'b0;
    logic       packet_valid, lbut, rbut, ident_valid, frame_err, sync_err;
    logic [7:0] dx, dy;

    int checks = 0;
    int passes = 0;

    ms_serial_mouse_rx #(.CLKFREQ(CLKFREQ), .BAUDRATE(BAUD), .TIMEOUT_MS(TMO_MS)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd), .rts(rts),
        .packet_valid(packet_valid), .dx(dx), .dy(dy), .lbut(lbut), .rbut(rbut),
        .ident_valid(ident_valid), .frame_err(frame_err), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Observed side: packets {lbut, rbut, dx, dy} and strobe counts, sampled mid-cycle
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int n_id = 0, n_fe = 0, n_se = 0;
    always @(negedge clk) begin
        if (packet_valid) got_q.push_back({lbut, rbut, dx, dy});
        if (ident_valid) n_id++;
        if (frame_err)   n_fe++;
        if (sync_err)    n_se++;
    end

    // Reference model working on whole bytes
    int         m_idx = 0;
    bit         m_ident = 1'b0;
    logic [6:0] m_b1, m_b2;
    int         e_id = 0, e_fe = 0, e_se = 0;

    task automatic model_byte(input logic [6:0] b);
        if (m_ident) begin
            m_ident = 1'b0;
            if (b == 7'h4D) begin e_id++; return; end
        end
        if (b[6]) begin
            m_b1 = b; m_idx = 1;
        end else if (m_idx == 0) begin
            e_se++;
        end else if (m_idx == 1) begin
            m_b2 = b; m_idx = 2;
        end else begin
            m_idx = 0;
            exp_q.push_back({m_b1[5], m_b1[4], m_b1[1:0], m_b2[5:0], m_b1[3:2], b[5:0]});
        end
    endtask

    task automatic clear_counts();
        got_q.delete(); exp_q.delete();
        n_id = 0; n_fe = 0; n_se = 0; e_id = 0; e_fe = 0; e_se = 0;
    endtask

    task automatic send_raw(input logic [6:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BPC) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rxd = b[i];
            repeat (BPC) @(negedge clk);
        end
        rxd = stop;
        repeat (BPC) @(negedge clk);
        if (stop) repeat ($urandom_range(2, BPC)) @(negedge clk);
    endtask

    task automatic tx(input logic [6:0] b);
        send_raw(b, 1'b1);
        model_byte(b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({packet_valid, dx, dy, lbut, rbut, ident_valid, frame_err, sync_err} !== 23'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {packet_valid, dx, dy, lbut, rbut, ident_valid, frame_err, sync_err});
        else passes++;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_packet();
        logic [17:0] g;
        clear_counts();
        tx(7'h6C); tx(7'h05); tx(7'h3D);
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) $display("FAIL basic_count: got %0d want 1", got_q.size());
        else passes++;
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (g !== {1'b1, 1'b0, 8'h05, 8'hFD}) $display("FAIL basic_fields: got %h want %h", g, {2'b10, 8'h05, 8'hFD});
            else passes++;
            checks++;
            if (g !== exp_q[0]) $display("FAIL basic_model: got %h want %h", g, exp_q[0]);
            else passes++;
        end
    endtask

    task automatic test_ident();
        logic [17:0] g;
        clear_counts();
        rts = 1'b1; m_idx = 0; m_ident = 1'b1;
        repeat (10) @(negedge clk);
        tx(7'h4D);
        repeat (5) @(negedge clk);
        checks++;
        if (n_id !== 1 || got_q.size() !== 0)
            $display("FAIL ident_strobe: got ident=%0d pkts=%0d want ident=1 pkts=0", n_id, got_q.size());
        else passes++;
        tx(7'h50); tx(7'h00); tx(7'h00);
        repeat (5) @(negedge clk);
        rts = 1'b0;
        checks++;
        if (got_q.size() !== 1) $display("FAIL ident_follow_count: got %0d want 1", got_q.size());
        else passes++;
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (g !== {1'b0, 1'b1, 8'h00, 8'h00}) $display("FAIL ident_follow_fields: got %h want %h", g, {2'b01, 16'h0000});
            else passes++;
        end
    endtask

    task automatic test_rts_abort();
        clear_counts();
        // RTS rises during the start bit of an all-ones byte; the rest of that byte has no falling edge
        fork
            send_raw(7'h7F, 1'b1);
            begin repeat (10) @(negedge clk); rts = 1'b1; end
        join
        m_idx = 0; m_ident = 1'b1;
        tx(7'h4D);
        tx(7'h12);
        repeat (5) @(negedge clk);
        rts = 1'b0;
        checks++;
        if (n_id !== e_id || n_se !== e_se || got_q.size() !== 0)
            $display("FAIL rts_abort: got ident=%0d sync=%0d pkts=%0d want ident=%0d sync=%0d pkts=0",
                     n_id, n_se, got_q.size(), e_id, e_se);
        else passes++;
    endtask

    task automatic test_frame_err();
        logic [17:0] g, e;
        clear_counts();
        send_raw(7'h6C, 1'b0);
        e_fe++;
        rxd = 1'b0;
        repeat (5 * MS) @(negedge clk);
        rxd = 1'b1;
        repeat (BPC) @(negedge clk);
        checks++;
        if (n_fe !== 1 || got_q.size() !== 0)
            $display("FAIL frame_err: got fe=%0d pkts=%0d want fe=1 pkts=0", n_fe, got_q.size());
        else passes++;
        tx(7'h40 | 7'($urandom_range(0, 63))); tx(7'($urandom_range(0, 63))); tx(7'($urandom_range(0, 63)));
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== 1 || exp_q.size() !== 1)
            $display("FAIL frame_recover_count: got %0d want %0d", got_q.size(), exp_q.size());
        else passes++;
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL frame_recover_fields: got %h want %h", g, e);
            else passes++;
        end
    endtask

    task automatic test_resync();
        logic [17:0] g;
        clear_counts();
        tx(7'h40); tx(7'h01); tx(7'h60); tx(7'h02); tx(7'h03);
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== 1) $display("FAIL resync_count: got %0d want 1", got_q.size());
        else passes++;
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (g !== {1'b1, 1'b0, 8'h02, 8'h03}) $display("FAIL resync_fields: got %h want %h", g, {2'b10, 8'h02, 8'h03});
            else passes++;
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        rxd = 1'b0;
        repeat (BPC / 5) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * BPC) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || n_id !== 0 || n_fe !== 0 || n_se !== 0)
            $display("FAIL glitch: got pkts=%0d id=%0d fe=%0d se=%0d want all 0", got_q.size(), n_id, n_fe, n_se);
        else passes++;
        tx(7'h12);
        repeat (5) @(negedge clk);
        checks++;
        if (n_se !== 1) $display("FAIL lone_sync_err: got %0d want 1", n_se);
        else passes++;
    endtask

    task automatic test_timeout();
        logic [17:0] g;
        clear_counts();
        tx(7'h40); tx(7'h01);
        repeat (15 * MS) @(negedge clk);
`ifdef MSRX_TIMEOUT_EN
        m_idx = 0;
`endif
        tx(7'h05);
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== exp_q.size() || n_se !== e_se)
            $display("FAIL timeout_counts: got pkts=%0d se=%0d want pkts=%0d se=%0d", got_q.size(), n_se, exp_q.size(), e_se);
        else passes++;
`ifndef MSRX_TIMEOUT_EN
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (g !== {2'b00, 8'h01, 8'h05}) $display("FAIL timeout_fields: got %h want %h", g, {2'b00, 8'h01, 8'h05});
            else passes++;
        end
`endif
    endtask

    task automatic test_random();
        logic [17:0] g, e;
        logic [7:0]  rx_, ry_;
        logic        l, r;
        int          npk;
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                rx_ = 8'($urandom); ry_ = 8'($urandom); l = 1'($urandom); r = 1'($urandom);
                tx({1'b1, l, r, ry_[7:6], rx_[7:6]});
                tx({1'b0, rx_[5:0]});
                tx({1'b0, ry_[5:0]});
            end else begin
                tx(7'($urandom_range(0, 127)));
            end
        end
        repeat (5) @(negedge clk);
        npk = exp_q.size();
        checks++;
        if (got_q.size() !== npk || n_se !== e_se || n_id !== 0)
            $display("FAIL random_counts: got pkts=%0d se=%0d id=%0d want pkts=%0d se=%0d id=0",
                     got_q.size(), n_se, n_id, npk, e_se);
        else passes++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) $display("FAIL random_packet: got %h want %h", g, e);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        tx(7'h60); tx(7'h02);
        fork
            send_raw(7'h03, 1'b1);
            begin
                repeat (3 * BPC) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                checks++;
                if ({packet_valid, dx, dy, lbut, rbut, ident_valid, frame_err, sync_err} !== 23'd0)
                    $display("FAIL reset_mid_outputs: got %h want 0",
                             {packet_valid, dx, dy, lbut, rbut, ident_valid, frame_err, sync_err});
                else passes++;
            end
        join
        reset_n = 1'b1;
        m_idx = 0; m_ident = 1'b0;
        repeat (4) @(negedge clk);
        tx(7'h03);
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || n_se !== 1)
            $display("FAIL reset_mid_drop: got pkts=%0d se=%0d want pkts=0 se=1", got_q.size(), n_se);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_ident();
        test_rts_abort();
        test_frame_err();
        test_resync();
        test_glitch();
        test_timeout();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
